alarm_timer: RTL and testbench

Seconds-based countdown timer that consumes the 4-bit interval value produced by the time-parameter register bank and reports expiry to the anti-theft control FSM. The FSM selects an interval on the parameter bank and pulses `start_timer`; this block samples `value`, counts whole seconds derived from the system clock, and pulses `expired` when the interval elapses. It also provides a free-running 1 Hz-derived blink signal for the status LED.

---
 rtl/alarm_timer.sv | 113 +++++++++++
 tb/tb_alarm_timer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timer.sv
// alarm_timer: seconds-based countdown timer with a free-running blink output.
// A start loads the interval from the parameter bank and counts it down in whole
// seconds of TICKS_PER_SEC clock cycles. The end of the interval is signalled by
// a one-cycle expired pulse.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   start_timer  load value and (re)start the countdown; has priority over stop
//   stop_timer   cancel a running countdown without an expired pulse
//   value[3:0]   interval in seconds, captured only on a start
//   expired      one-cycle pulse at the end of an interval (or on a start with 0)
//   running      high while a countdown is in progress
//   remaining    seconds left in the current countdown
//   blink        square wave that toggles every TICKS_PER_SEC cycles
module alarm_timer #(
   parameter int unsigned TICKS_PER_SEC = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_timer,
   input  logic       stop_timer,
   input  logic [3:0] value,
   output logic       expired,
   output logic       running,
   output logic [3:0] remaining,
   output logic       blink
);

   localparam int unsigned TPW = $clog2(TICKS_PER_SEC);
   localparam logic [TPW-1:0] TP_MAX = TPW'(TICKS_PER_SEC - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [TPW-1:0]   tp_q, tp_d;
   logic [3:0]       remaining_q, remaining_d;
   logic             expired_q, expired_d;
   logic [TPW-1:0]   bp_q, bp_d;
   logic             blink_q, blink_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tp_q        <= '0;
         remaining_q <= '0;
         expired_q   <= 1'b0;
         bp_q        <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tp_q        <= tp_d;
         remaining_q <= remaining_d;
         expired_q   <= expired_d;
         bp_q        <= bp_d;
         blink_q     <= blink_d;
      end
   end

   // Countdown control. A start overrides both a stop and an expiry on the
   // same edge, so a reload never produces a stale pulse.
   always_comb begin
      state_d     = state_q;
      tp_d        = tp_q;
      remaining_d = remaining_q;
      expired_d   = 1'b0;

      if (start_timer) begin
         remaining_d = value;
         tp_d        = '0;
         if (value != '0) begin
            state_d = RUN;
         end else begin
            state_d   = IDLE;
            expired_d = 1'b1;
         end
      end else if (stop_timer && state_q == RUN) begin
         state_d     = IDLE;
         remaining_d = '0;
         tp_d        = '0;
      end else if (state_q == RUN) begin
         if (tp_q == TP_MAX) begin
            tp_d        = '0;
            remaining_d = remaining_q - 4'd1;
            if (remaining_q == 4'd1) begin
               state_d   = IDLE;
               expired_d = 1'b1;
            end
         end else begin
            tp_d = tp_q + TPW'(1);
         end
      end
   end

   // Blink prescaler runs regardless of the countdown.
   always_comb begin
      bp_d    = bp_q + TPW'(1);
      blink_d = blink_q;
      if (bp_q == TP_MAX) begin
         bp_d    = '0;
         blink_d = ~blink_q;
      end
   end

   assign expired   = expired_q;
   assign running   = (state_q == RUN);
   assign remaining = remaining_q;
   assign blink     = blink_q;

endmodule

// File: tb/tb_alarm_timer.sv
module tb_alarm_timer;

   localparam int T = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_timer = 1'b0;
   logic       stop_timer = 1'b0;
   logic [3:0] value = 4'd0;
   logic       expired;
   logic       running;
   logic [3:0] remaining;
   logic       blink;

   int total = 0;
   int bad = 0;

   // Reference model: countdown described by start edge index and length,
   // blink described by the number of edges since reset release.
   int cyc = 0;
   int blink_edges = 0;
   bit m_run = 0;
   int m_start = 0;
   int m_n = 0;
   int m_rem = 0;
   bit m_exp = 0;
   bit m_blink = 0;

   alarm_timer #(.TICKS_PER_SEC(T)) dut (
      .clock(clock),
      .reset(reset),
      .start_timer(start_timer),
      .stop_timer(stop_timer),
      .value(value),
      .expired(expired),
      .running(running),
      .remaining(remaining),
      .blink(blink)
   );

   always #5 clock = ~clock;

   task automatic model_clear();
      cyc = 0;
      blink_edges = 0;
      m_run = 0;
      m_rem = 0;
      m_exp = 0;
      m_blink = 0;
   endtask

   task automatic model_edge(input bit st, input bit sp, input int v);
      int elapsed;
      cyc++;
      blink_edges++;
      m_blink = ((blink_edges / T) % 2) == 1;
      m_exp = 0;
      if (st) begin
         m_n = v;
         m_start = cyc;
         if (v == 0) begin
            m_run = 0;
            m_rem = 0;
            m_exp = 1;
         end else begin
            m_run = 1;
            m_rem = v;
         end
      end else if (sp && m_run) begin
         m_run = 0;
         m_rem = 0;
      end else if (m_run) begin
         elapsed = cyc - m_start;
         m_rem = m_n - elapsed / T;
         if (elapsed == m_n * T) begin
            m_run = 0;
            m_exp = 1;
            m_rem = 0;
         end
      end
   endtask

   // Drive inputs from the falling edge, apply one rising edge, return at the
   // next falling edge where outputs are sampled.
   task automatic tick(input bit st, input bit sp, input logic [3:0] v);
      start_timer = st;
      stop_timer = sp;
      value = v;
      @(posedge clock);
      if (reset) model_clear();
      else model_edge(st, sp, int'(v));
      @(negedge clock);
      start_timer = 1'b0;
      stop_timer = 1'b0;
      value = 4'($urandom_range(0, 15));
   endtask

   task automatic test_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      model_clear();
      #1;
      total++;
      if ({expired, running, remaining, blink} !== 7'd0) begin
         bad++;
         $display("FAIL reset_async: got exp=%0b run=%0b rem=%0d blink=%0b, want all 0",
                  expired, running, remaining, blink);
      end
      tick(0, 0, 0);
      tick(0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic test_countdown();
      int pulses = 0;
      int at = -1;
      tick(1, 0, 6);
      for (int i = 1; i <= 32; i++) begin
         tick(0, 0, 4'($urandom_range(0, 15)));
         total++;
         if ({expired, running, remaining, blink} !== {m_exp, m_run, 4'(m_rem), m_blink}) begin
            bad++;
            $display("FAIL countdown_cyc%0d: got %b%b_%0d_%b, want %b%b_%0d_%b", i,
                     expired, running, remaining, blink, m_exp, m_run, m_rem, m_blink);
         end
         if (expired) begin
            pulses++;
            at = i;
         end
      end
      total++;
      if (pulses != 1 || at != 24) begin
         bad++;
         $display("FAIL countdown_pulse: got %0d pulses last at edge %0d, want 1 at edge 24", pulses, at);
      end
   endtask

   task automatic test_zero();
      tick(1, 0, 0);
      total++;
      if (expired !== 1'b1 || running !== 1'b0) begin
         bad++;
         $display("FAIL zero_start: got exp=%0b run=%0b, want exp=1 run=0", expired, running);
      end
      tick(0, 0, 0);
      total++;
      if (expired !== 1'b0 || running !== 1'b0) begin
         bad++;
         $display("FAIL zero_after: got exp=%0b run=%0b, want exp=0 run=0", expired, running);
      end
   endtask

   task automatic test_restart();
      int pulses = 0;
      int at = -1;
      tick(1, 0, 8);
      for (int i = 1; i <= 10; i++) begin
         tick(0, 0, 4'($urandom_range(0, 15)));
         if (expired) pulses++;
      end
      tick(1, 0, 3);
      if (expired) pulses++;
      for (int i = 1; i <= 40; i++) begin
         tick(0, 0, 4'($urandom_range(0, 15)));
         total++;
         if ({expired, running, remaining} !== {m_exp, m_run, 4'(m_rem)}) begin
            bad++;
            $display("FAIL restart_cyc%0d: got %b%b_%0d, want %b%b_%0d", i,
                     expired, running, remaining, m_exp, m_run, m_rem);
         end
         if (expired) begin
            pulses++;
            at = i;
         end
      end
      total++;
      if (pulses != 1 || at != 12) begin
         bad++;
         $display("FAIL restart_pulse: got %0d pulses last at edge %0d, want 1 at edge 12", pulses, at);
      end
   endtask

   task automatic test_stop();
      int pulses = 0;
      int at = -1;
      tick(1, 0, 5);
      for (int i = 1; i <= 6; i++) tick(0, 0, 0);
      tick(0, 1, 0);
      total++;
      if (running !== 1'b0 || remaining !== 4'd0) begin
         bad++;
         $display("FAIL stop_state: got run=%0b rem=%0d, want run=0 rem=0", running, remaining);
      end
      for (int i = 1; i <= 30; i++) begin
         tick(0, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
         if (expired) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL stop_nopulse: got %0d pulses, want 0", pulses);
      end
      pulses = 0;
      tick(1, 1, 2);
      for (int i = 1; i <= 12; i++) begin
         tick(0, 0, 0);
         if (expired) begin
            pulses++;
            at = i;
         end
      end
      total++;
      if (pulses != 1 || at != 8) begin
         bad++;
         $display("FAIL start_stop_prio: got %0d pulses last at edge %0d, want 1 at edge 8", pulses, at);
      end
   endtask

   task automatic test_reset_midrun();
      int pulses = 0;
      tick(1, 0, 6);
      for (int i = 1; i <= 8; i++) tick(0, 0, 0);
      total++;
      if (remaining !== 4'd4) begin
         bad++;
         $display("FAIL midrun_rem: got %0d, want 4", remaining);
      end
      #2 reset = 1'b1;
      model_clear();
      #1;
      total++;
      if ({expired, running, remaining, blink} !== 7'd0) begin
         bad++;
         $display("FAIL midrun_reset: got exp=%0b run=%0b rem=%0d blink=%0b, want all 0",
                  expired, running, remaining, blink);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick(0, 0, 4'($urandom_range(0, 15)));
         total++;
         if ({expired, running, remaining, blink} !== {m_exp, m_run, 4'(m_rem), m_blink}) begin
            bad++;
            $display("FAIL midrun_after_cyc%0d: got %b%b_%0d_%b, want %b%b_%0d_%b", i,
                     expired, running, remaining, blink, m_exp, m_run, m_rem, m_blink);
         end
         if (expired) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL midrun_nopulse: got %0d pulses, want 0", pulses);
      end
   endtask

   task automatic test_random();
      for (int i = 1; i <= 600; i++) begin
         tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
              4'($urandom_range(0, 15)));
         total++;
         if ({expired, running, remaining, blink} !== {m_exp, m_run, 4'(m_rem), m_blink}) begin
            bad++;
            $display("FAIL random_cyc%0d: got %b%b_%0d_%b, want %b%b_%0d_%b", i,
                     expired, running, remaining, blink, m_exp, m_run, m_rem, m_blink);
         end
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_zero();
      test_restart();
      test_stop();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
